// File: rtl/risc_ctrl_pkg.sv
// Shared definitions for the multicycle RISC control path: opcodes, ALU/mux
// encodings and the main control FSM state enum.
// Optional feature macro: ILLEGAL_TRAP_EN (adds the TRAP state).
package risc_ctrl_pkg;

    // Opcode field, instruction bits [15:12]
    localparam logic [3:0] OP_LD  = 4'b0000;
    localparam logic [3:0] OP_ST  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLT = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1011;
    localparam logic [3:0] OP_BNE = 4'b1100;
    localparam logic [3:0] OP_JMP = 4'b1101;

    // ALU operation class handed to the ALU control decoder
    localparam logic [1:0] ALUOP_FUNC = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_ADD  = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_TWO    = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
`ifdef ILLEGAL_TRAP_EN
        S_JUMP     = 4'd9,
        S_TRAP     = 4'd10
`else
        S_JUMP     = 4'd9
`endif
    } state_t;

    // R-type opcodes occupy the contiguous range ADD..SLT
    function automatic logic is_rtype(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_SLT);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the main control FSM (master) and the datapath /
// memory (slave). Optional feature macro: ILLEGAL_TRAP_EN (adds illegal_op).
interface multicycle_control_if;
    logic [3:0] opcode;
    logic       mem_ready;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_cond_ne;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    modport master (
        input  opcode, mem_ready,
        output ir_write, pc_write, pc_write_cond, pc_write_cond_ne,
               mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, pc_src,
`ifdef ILLEGAL_TRAP_EN
               illegal_op,
`endif
               instr_done
    );

    modport slave (
        output opcode, mem_ready,
        input  ir_write, pc_write, pc_write_cond, pc_write_cond_ne,
               mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, pc_src,
`ifdef ILLEGAL_TRAP_EN
               illegal_op,
`endif
               instr_done
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the 16-bit RISC core: sequences
// fetch/decode/execute/memory/write-back and drives datapath controls.
// Optional feature macro: ILLEGAL_TRAP_EN (undefined opcodes trap).
module multicycle_control
    import risc_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    multicycle_control_if.master  bus
);

    state_t state_q, state_d;
    // Branch flavour captured in DECODE so BRANCH ignores later opcode changes
    logic   bne_q, bne_d;

    // State register with synchronous reset into FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            bne_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bne_q   <= bne_d;
        end
    end

    // Next-state and per-state control outputs
    always_comb begin
        state_d              = state_q;
        bne_d                = bne_q;
        bus.ir_write         = 1'b0;
        bus.pc_write         = 1'b0;
        bus.pc_write_cond    = 1'b0;
        bus.pc_write_cond_ne = 1'b0;
        bus.mem_read         = 1'b0;
        bus.mem_write        = 1'b0;
        bus.iord             = 1'b0;
        bus.reg_write        = 1'b0;
        bus.reg_dst          = 1'b0;
        bus.mem_to_reg       = 1'b0;
        bus.alu_src_a        = 1'b0;
        bus.alu_src_b        = SRCB_REG;
        bus.alu_op           = ALUOP_FUNC;
        bus.pc_src           = PCSRC_ALU;
        bus.instr_done       = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        bus.illegal_op       = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_TWO;
                bus.alu_op    = ALUOP_ADD;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut
                bus.alu_src_b = SRCB_IMM_SH;
                bus.alu_op    = ALUOP_ADD;
                bne_d         = (bus.opcode == OP_BNE);
                if (bus.opcode == OP_LD || bus.opcode == OP_ST) begin
                    state_d = S_MEM_ADDR;
                end else if (is_rtype(bus.opcode)) begin
                    state_d = S_EXEC_R;
                end else if (bus.opcode == OP_BEQ || bus.opcode == OP_BNE) begin
                    state_d = S_BRANCH;
                end else if (bus.opcode == OP_JMP) begin
                    state_d = S_JUMP;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    // Undefined opcode retires as a two-cycle NOP
                    bus.instr_done = 1'b1;
                    state_d        = S_FETCH;
`endif
                end
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.alu_op    = ALUOP_ADD;
                state_d       = (bus.opcode == OP_ST) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
                if (bus.mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEM_WR: begin
                bus.mem_write  = 1'b1;
                bus.iord       = 1'b1;
                bus.instr_done = bus.mem_ready;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_REG;
                bus.alu_op    = ALUOP_FUNC;
                state_d       = S_R_WB;
            end
            S_R_WB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a        = 1'b1;
                bus.alu_src_b        = SRCB_REG;
                bus.alu_op           = ALUOP_SUB;
                bus.pc_src           = PCSRC_ALUOUT;
                bus.instr_done       = 1'b1;
                bus.pc_write_cond    = ~bne_q;
                bus.pc_write_cond_ne = bne_q;
                state_d              = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_write   = 1'b1;
                bus.pc_src     = PCSRC_JUMP;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                // Parked until reset with every datapath control deasserted
                bus.illegal_op = 1'b1;
                state_d        = S_TRAP;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle main control FSM for the 16-bit RISC core. It sequences fetch, decode, execute, memory and write-back for each instruction, driving datapath enables and muxes. It also issues the 2-bit `alu_op` class code that the downstream ALU control decoder expands, together with the 4-bit opcode, into the 3-bit ALU function. Memory accesses stall on a ready handshake.

## Interface
- Parameters: none.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 4: instruction register bits [15:12]; valid from DECODE onward.
- `mem_ready` in 1: memory completes the current read/write this cycle.
- `ir_write`, `pc_write`, `pc_write_cond`, `pc_write_cond_ne` out 1 each: IR load; unconditional PC load; PC load if zero; PC load if not zero.
- `mem_read`, `mem_write`, `iord` out 1 each: memory read; memory write; address from ALUOut (1) or PC (0).
- `reg_write`, `reg_dst`, `mem_to_reg` out 1 each: register-file write; destination rd (1) or rt (0); write data from MDR (1) or ALUOut (0).
- `alu_src_a` out 1: ALU A is register A (1) or PC (0).
- `alu_src_b` out 2: 00 = reg B, 01 = constant 2, 10 = sign-ext imm, 11 = sign-ext imm << 1.
- `alu_op` out 2: 10 = add, 01 = subtract, 00 = function from opcode.
- `pc_src` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_done` out 1: one-cycle pulse in the final state of each instruction.
- `illegal_op` out 1: present only with `ILLEGAL_TRAP_EN`.

## Operation
- Opcodes:
  - 0000 LD; 0001 ST.
  - 0010–1001 R-type: ADD, SUB, INV, LSL, LSR, AND, OR, SLT.
  - 1011 BEQ; 1100 BNE; 1101 JMP.
  - 1010, 1110, 1111 undefined.
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, BRANCH, JUMP, TRAP (with macro only).
- Outputs are a function of state, plus `mem_ready` where stated. Any output not listed for a state is 0.
- FETCH:
  - `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=10, `pc_src`=00.
  - `ir_write`=`pc_write`=`mem_ready`.
  - Stay in FETCH while `mem_ready`=0; otherwise go to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=10 (branch target into ALUOut). Next state by opcode:
  - LD/ST → MEM_ADDR.
  - R-type → EXEC_R.
  - BEQ/BNE → BRANCH.
  - JMP → JUMP.
  - Undefined → TRAP with macro, FETCH without.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=10. Next: MEM_RD for LD, MEM_WR for ST.
- MEM_RD: `mem_read`=1, `iord`=1. Hold until `mem_ready`, then go to MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `instr_done`=1. Next: FETCH.
- MEM_WR: `mem_write`=1, `iord`=1. Hold until `mem_ready`. `instr_done`=`mem_ready`; go to FETCH on `mem_ready`.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=00. Next: R_WB.
- R_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `instr_done`=1. Next: FETCH.
- BRANCH:
  - `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_src`=01, `instr_done`=1.
  - `pc_write_cond`=1 for BEQ; `pc_write_cond_ne`=1 for BNE. Never both.
  - Next: FETCH.
- JUMP: `pc_write`=1, `pc_src`=10, `instr_done`=1. Next: FETCH.
- `mem_read` and `mem_write` are never high together. `reg_write` is never high in a memory-wait state.

## Timing
- Reset: on the first rising edge with `reset`=1 the state becomes FETCH. Reset values are the FETCH outputs: `mem_read`=1, `alu_op`=10, `alu_src_b`=01, all others 0; `ir_write`/`pc_write` follow `mem_ready`.
- `reset` asserted in any state, including a memory wait, aborts the instruction. Writes already committed are not undone.
- Cycles per instruction with `mem_ready` tied high: LD 5, ST 4, R-type 4, BEQ/BNE 3, JMP 3.
- Each cycle of `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- `opcode` is sampled in DECODE and MEM_ADDR only. Changes in other states are ignored.

## Configuration
- `ILLEGAL_TRAP_EN` defined:
  - Undefined opcodes go to TRAP, which holds until reset.
  - In TRAP, `illegal_op`=1 and all other outputs are 0.
  - `illegal_op` is 0 in every other state.
- `ILLEGAL_TRAP_EN` undefined:
  - The `illegal_op` port and the TRAP state are absent.
  - Undefined opcodes return DECODE → FETCH with `instr_done`=1 in DECODE (2-cycle NOP).

## Structure
- Shared package `risc_ctrl_pkg` holds:
  - Opcode constants.
  - `alu_op` encodings (ALUOP_ADD=10, ALUOP_SUB=01, ALUOP_FUNC=00).
  - `alu_src_b` and `pc_src` encodings.
  - State enum, 4-bit.
- No sub-module. The block is a single state register plus next-state and output decode.

## Test plan
- Reset then ADD (opcode 0010), `mem_ready`=1 → states FETCH, DECODE, EXEC_R, R_WB; `alu_op`=00 in EXEC_R; `reg_write`=`reg_dst`=1 in cycle 4; `instr_done` pulses once.
- LD with `mem_ready` low for 3 cycles in MEM_RD → MEM_RD held 4 cycles; `reg_write`=1, `mem_to_reg`=1 only in MEM_WB; total 8 cycles.
- BEQ (1011) and BNE (1100) → 3 cycles each; `alu_op`=01; only the matching cond-write is high, with `pc_src`=01.
- JMP (1101) → `pc_write`=1, `pc_src`=10 in cycle 3; next cycle is FETCH.
- Opcode 1110:
  - With macro: TRAP entered, `illegal_op`=1 held, no further `mem_read`.
  - Without macro: FETCH on cycle 3.
- `reset` asserted during a MEM_WR wait → FETCH next cycle; `mem_write`=0 immediately after the edge.
